// File: rtl/regfile_pkg.sv
// Shared defaults, address/data typedefs and the zero-register index helper
// for the regfile_sb register file and its pending scoreboard.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_NRD   = 2;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
  typedef logic [DEFAULT_WIDTH-1:0] reg_data_t;

  // The hard-wired zero register (XZR) is always the highest index.
  function automatic int zr_idx(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus a running popcount, with set-wins arbitration
// between producer issue (set) and writeback (clear), and zero-register masking.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int   DEPTH    = DEFAULT_DEPTH,
  parameter int   ZERO_REG = 1,
  localparam int  AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] pend,
  output logic [AW:0]      pend_cnt
);

  localparam logic [AW-1:0] ZR = AW'(zr_idx(DEPTH));

  logic [DEPTH-1:0] pend_d, pend_q;
  logic [AW:0]      cnt_d, cnt_q;
  logic             set_ok, clr_ok, inc, dec;

  always_comb begin
    set_ok = set_en && !((ZERO_REG != 0) && (set_addr == ZR));
    clr_ok = clr_en && !((ZERO_REG != 0) && (clr_addr == ZR));
    // A set on the same address as a clear cancels the clear, so only the
    // set side can move the count for that bit.
    inc    = set_ok && !pend_q[set_addr];
    dec    = clr_ok && pend_q[clr_addr] && !(set_ok && (set_addr == clr_addr));

    pend_d = pend_q;
    if (clr_ok) pend_d[clr_addr] = 1'b0;
    if (set_ok) pend_d[set_addr] = 1'b1;

    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with NRD combinational read ports, one write port,
// optional zero register and a pending scoreboard. REGFILE_BYPASS_EN adds write-through forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = DEFAULT_WIDTH,
  parameter int  DEPTH    = DEFAULT_DEPTH,
  parameter int  NRD      = DEFAULT_NRD,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we3,
  input  logic [AW-1:0]             wa3,
  input  logic [WIDTH-1:0]          wd3,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][WIDTH-1:0] rd,
  output logic [NRD-1:0]            rd_pend,
  input  logic                      pend_set,
  input  logic [AW-1:0]             pend_addr,
  output logic [AW:0]               pend_cnt
);

  localparam logic [AW-1:0] ZR = AW'(zr_idx(DEPTH));

  logic [DEPTH-1:0][WIDTH-1:0] mem_d, mem_q;
  logic [DEPTH-1:0]            pend;
  logic                        wr_en;

  assign wr_en = we3 && !((ZERO_REG != 0) && (wa3 == ZR));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wa3] = wd3;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (pend_set),
    .set_addr (pend_addr),
    .clr_en   (we3),
    .clr_addr (wa3),
    .pend     (pend),
    .pend_cnt (pend_cnt)
  );

  always_comb begin
    rd      = '0;
    rd_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      if ((ZERO_REG != 0) && (ra[k] == ZR)) begin
        rd[k]      = '0;
        rd_pend[k] = 1'b0;
      end else begin
        rd[k]      = mem_q[ra[k]];
        rd_pend[k] = pend[ra[k]];
`ifdef REGFILE_BYPASS_EN
        // Writeback value is ready this cycle, so it masks any stored pend bit.
        if (wr_en && (ra[k] == wa3)) begin
          rd[k]      = wd3;
          rd_pend[k] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x64 two-read/one-write integer register file of the pipelined LEGv8 core.
- Generalised in width, depth and read-port count.
- Adds synchronous clear and an optional hard-wired zero register (XZR).
- Adds a per-register pending scoreboard for in-flight producers (loads, multi-cycle ops). The hazard unit uses it to stall on reads of not-yet-written registers.
- Sits in the ID stage; writeback drives the write port.

Parameters:
- WIDTH, 64, data bits per register.
- DEPTH, 32, number of registers (power of two, >=2); AW = $clog2(DEPTH).
- NRD, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, if 1 register DEPTH-1 reads 0, ignores writes, never goes pending.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- we3  in  1  write enable.
- wa3  in  AW  write address.
- wd3  in  WIDTH  write data.
- ra  in  NRD x AW  read addresses, port k = ra[k].
- rd  out  NRD x WIDTH  read data, combinational from ra.
- rd_pend  out  NRD  1 = register on port k has an outstanding producer.
- pend_set  in  1  mark pend_addr as pending (issue of a producer).
- pend_addr  in  AW  register being marked.
- pend_cnt  out  AW+1  number of registers currently pending.

Behaviour:
- Reset: on a rising edge with reset=1, all registers become 0, all pending bits 0, pend_cnt 0. we3 and pend_set are ignored that cycle. Afterwards every rd = 0 and rd_pend = 0. Reset mid-operation discards in-flight pending state; no partial update.
- Write: on a rising edge with we3=1 and reset=0, reg[wa3] <= wd3 and pend[wa3] <= 0, unless pend_set targets the same address that edge (see below). Write to the zero register (ZERO_REG=1, wa3=DEPTH-1) is dropped and its pend bit stays 0.
- Read: rd[k] = reg[ra[k]], purely combinational, zero cycles latency. ra[k]=DEPTH-1 with ZERO_REG=1 gives 0. Without bypass, a read of wa3 in the same cycle as its write returns the old value; the new value is visible the cycle after the edge.
- Scoreboard set: on a rising edge with pend_set=1 and reset=0, pend[pend_addr] <= 1. Setting an already-pending bit is a no-op. pend_set to the zero register is ignored.
- Simultaneous set and clear, same address (pend_set & we3, pend_addr==wa3): the register is written AND set wins, so pend stays/becomes 1. A younger producer has issued as the older retires.
- pend_cnt: registered; updated on the same edge as the pend bits, always equal to the popcount of pend[].
  - +1 on set of a 0 bit.
  - -1 on clear of a 1 bit.
  - Net 0 when both events hit an already-pending bit.
  - +1 when both hit a non-pending bit.
  - Never wraps (max DEPTH-1 with ZERO_REG=1, DEPTH otherwise).
- rd_pend[k] = pend[ra[k]]; always 0 for the zero register.
- Multiple read ports may read the same address; all return identical data.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When we3=1 and ra[k]==wa3 (not the zero register), rd[k] = wd3 in the same cycle and rd_pend[k] = 0 (value is ready), regardless of pend[wa3]. This removes the WB->ID hazard, so the hazard unit drops the one-cycle stall.
- Not defined: reads return stored contents only (old value during the write cycle). rd_pend reflects the stored pend bit.

Decomposition:
- Package regfile_pkg: default WIDTH/DEPTH/NRD, the zero-register index function zr_idx(DEPTH), and typedefs for register address and data.
- One sub-module regfile_scoreboard: holds pend[] and pend_cnt, plus set/clear arbitration and zero-register masking.
- The top holds the storage array, read muxes and the bypass logic.

Test Plan:
- Reset: write 64'h0123_4567_89AB_CDEF to x4, assert reset one cycle, read x4 -> 0; pend_cnt=0; all rd_pend=0.
- Write/read: we3=1, wa3=4, wd3=64'h0123_4567_89AB_CDEF; same-cycle ra[0]=4 returns old 0 (no bypass) or the new value with REGFILE_BYPASS_EN; next cycle returns 64'h0123_4567_89AB_CDEF. A following cycle with we3=0, wd3=64'hFEDC_BA98_7654_3210 leaves x4 unchanged.
- Zero register: we3=1, wa3=31, wd3=all-ones; then ra[1]=31 -> 0. pend_set with pend_addr=31 -> rd_pend=0 and pend_cnt unchanged.
- Scoreboard: pend_set x5 -> next cycle rd_pend=1, pend_cnt=1. Set x5 again -> pend_cnt=1. Write x5 -> rd_pend=0, pend_cnt=0.
- Simultaneous events: x7 pending, pend_set x7 with we3 wa3=7 wd3=64'hAA on the same edge -> x7=64'hAA, still pending, pend_cnt unchanged. Repeat on non-pending x8 -> pending, pend_cnt +1.
- Parameter sweep: WIDTH=32, DEPTH=16, NRD=3, ZERO_REG=0. Fill all 16 registers with their index; all three ports read distinct addresses correctly; register 15 is writable. Set all 16 pending -> pend_cnt=16 with no wrap.
